// File: rtl/testing_mem_checker.sv
// Avalon-MM BIST initiator: write a pattern over a word range, read it back, compare.
// Latency: 2N+2 cycles from accepted start to done (N writes, N reads, one drain).
// Backpressure: none; the slave has no waitrequest, so one access is issued every cycle.
module testing_mem_checker #(
  parameter int          ADDR_W = 14,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [ADDR_W:0]     num_words_i,
  input  logic                pattern_mode_i,
  output logic [ADDR_W-1:0]   mem_address_o,
  output logic [DATA_W/8-1:0] mem_byteenable_o,
  output logic                mem_chipselect_o,
  output logic                mem_write_o,
  output logic [DATA_W-1:0]   mem_writedata_o,
  output logic                mem_clken_o,
  input  logic [DATA_W-1:0]   mem_readdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_count_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic [DATA_W-1:0]   first_err_data_o
);

  localparam logic [31:0] TAPS     = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic                mode_q, mode_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                exp_vld_q, exp_vld_d;
  logic [DATA_W-1:0]   exp_dat_q, exp_dat_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0]   ferr_dat_q, ferr_dat_d;

  // Word address of the current access wraps naturally at 2^ADDR_W.
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] pat;
  logic [31:0]       lfsr_nxt;
  logic              last;
  logic              mismatch;

  // Per-word pattern, LFSR advance and end-of-range detection.
  always_comb begin
    cur_addr = base_q + idx_q[ADDR_W-1:0];
    pat      = mode_q ? DATA_W'(lfsr_q) : DATA_W'(cur_addr);
    lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
    last     = (idx_q == (num_q - (ADDR_W+1)'(1)));
    mismatch = exp_vld_q && (mem_readdata_i != exp_dat_q);
  end

  // State and datapath registers; reset aborts any run and idles the bus.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      lfsr_q      <= SEED_EFF;
      exp_vld_q   <= 1'b0;
      exp_dat_q   <= '0;
      exp_addr_q  <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_dat_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      lfsr_q      <= lfsr_d;
      exp_vld_q   <= exp_vld_d;
      exp_dat_q   <= exp_dat_d;
      exp_addr_q  <= exp_addr_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_dat_q  <= ferr_dat_d;
    end
  end

  // Next-state, bus strobes and compare/error bookkeeping.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    num_d            = num_q;
    mode_d           = mode_q;
    idx_d            = idx_q;
    lfsr_d           = lfsr_q;
    exp_vld_d        = 1'b0;
    exp_dat_d        = exp_dat_q;
    exp_addr_d       = exp_addr_q;
    err_d            = err_q;
    ferr_addr_d      = ferr_addr_q;
    ferr_dat_d       = ferr_dat_q;
    mem_address_o    = '0;
    mem_chipselect_o = 1'b0;
    mem_write_o      = 1'b0;
    mem_writedata_o  = '0;

    // The read returned this cycle belongs to the address registered with exp_*.
    if (mismatch) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (err_q == 16'd0) begin
        ferr_addr_d = exp_addr_q;
        ferr_dat_d  = mem_readdata_i;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          base_d      = base_addr_i;
          num_d       = num_words_i;
          mode_d      = pattern_mode_i;
          idx_d       = '0;
          lfsr_d      = SEED_EFF;
          err_d       = '0;
          ferr_addr_d = '0;
          ferr_dat_d  = '0;
          state_d     = (num_words_i == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_chipselect_o = 1'b1;
        mem_write_o      = 1'b1;
        mem_address_o    = cur_addr;
        mem_writedata_o  = pat;
        idx_d            = idx_q + (ADDR_W+1)'(1);
        lfsr_d           = lfsr_nxt;
        if (last) begin
          // Restart the generator so the read phase reproduces the same words.
          idx_d   = '0;
          lfsr_d  = SEED_EFF;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        mem_chipselect_o = 1'b1;
        mem_address_o    = cur_addr;
        exp_vld_d        = 1'b1;
        exp_dat_d        = pat;
        exp_addr_d       = cur_addr;
        idx_d            = idx_q + (ADDR_W+1)'(1);
        lfsr_d           = lfsr_nxt;
        if (last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_byteenable_o = '1;
  assign mem_clken_o      = 1'b1;
  assign busy_o           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done_o           = (state_q == ST_DONE);
  assign pass_o           = (state_q == ST_DONE) && (err_q == 16'd0);
  assign err_count_o      = err_q;
  assign first_err_addr_o = ferr_addr_q;
  assign first_err_data_o = ferr_dat_q;

endmodule

// File: tb/tb_testing_mem_checker.sv
// Bench for testing_mem_checker: memory slave model with read-side fault injection,
// directed vector table, randomized runs against a word-list reference, reset corners.
module tb_testing_mem_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] num_words;
  logic        pattern_mode;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [13:0] first_err_addr;
  logic [31:0] first_err_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:16383];
  logic        fault_en = 1'b0;
  logic [13:0] fault_addr = '0;
  logic [31:0] exp_words [0:16383];

  always #5 clk = ~clk;

  testing_mem_checker dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .num_words_i      (num_words),
    .pattern_mode_i   (pattern_mode),
    .mem_address_o    (mem_address),
    .mem_byteenable_o (mem_byteenable),
    .mem_chipselect_o (mem_chipselect),
    .mem_write_o      (mem_write),
    .mem_writedata_o  (mem_writedata),
    .mem_clken_o      (mem_clken),
    .mem_readdata_i   (mem_readdata),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr),
    .first_err_data_o (first_err_data)
  );

  // Single-port memory slave: read data returned one cycle after the address.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem[mem_address] <= mem_writedata;
      else mem_readdata <= mem[mem_address] ^ {31'd0, (fault_en && mem_address == fault_addr)};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word i of a run: base+i for address mode, i-th LFSR state otherwise.
  task automatic build(input int base, input int n, input bit mode);
    logic [31:0] l;
    l = 32'd1;
    for (int i = 0; i < n; i++) begin
      exp_words[i] = mode ? l : 32'((base + i) % 16384);
      l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
    end
  endtask

  typedef struct {
    int          base;
    int          n;
    bit          mode;
    bit          fen;
    int          faddr;
    bit          start_mid;
    bit          exp_pass;
    int          exp_err;
    int          exp_faddr;
    logic [31:0] exp_fdata;
  } vec_t;

  task automatic run_test(input vec_t v);
    int bus_bad, busy_bad, done_cyc, idx, exp_done;
    bit ecs, ewe;
    build(v.base, v.n, v.mode);
    fault_en     = v.fen;
    fault_addr   = 14'(v.faddr);
    base_addr    = 14'(v.base);
    num_words    = 15'(v.n);
    pattern_mode = v.mode;
    start        = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 14'($urandom);   // must have been captured at start
    num_words = 15'($urandom);
    bus_bad   = 0;
    busy_bad  = 0;
    done_cyc  = -1;
    exp_done  = (v.n == 0) ? 1 : 2 * v.n + 2;
    for (int c = 1; c <= 2 * v.n + 6; c++) begin
      ecs = (c <= 2 * v.n);
      ewe = (c <= v.n);
      idx = (c <= v.n) ? c - 1 : c - v.n - 1;
      if (mem_chipselect !== ecs || mem_write !== ewe) bus_bad++;
      else if (ecs && mem_address !== 14'((v.base + idx) % 16384)) bus_bad++;
      else if (!ecs && mem_address !== 14'd0) bus_bad++;
      else if (ewe && mem_writedata !== exp_words[idx]) bus_bad++;
      else if (!ewe && mem_writedata !== 32'd0) bus_bad++;
      if (mem_byteenable !== 4'hF || mem_clken !== 1'b1) bus_bad++;
      if (busy !== (v.n > 0 && c <= 2 * v.n + 1)) busy_bad++;
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      start = v.start_mid && (c == 2);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("bus_seq", 64'(bus_bad), 64'd0);
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("done_cycle", 64'(done_cyc), 64'(exp_done));
    chk("pass", 64'(pass), 64'(v.exp_pass));
    chk("err_count", 64'(err_count), 64'(v.exp_err));
    chk("first_err_addr", 64'(first_err_addr), 64'(v.exp_faddr));
    chk("first_err_data", 64'(first_err_data), 64'(v.exp_fdata));
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    int n, off;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; pattern_mode = 1'b0;
    // Directed vectors: base, n, mode, fault en/addr, start-while-busy, expectations.
    tbl.push_back('{0,     4,     0, 0, 0,   0, 1, 0, 0, 32'h0});
    tbl.push_back('{0,     3,     1, 0, 0,   0, 1, 0, 0, 32'h0});
    tbl.push_back('{0,     8,     0, 1, 5,   0, 0, 1, 5, 32'h4});
    tbl.push_back('{16382, 4,     0, 0, 0,   0, 1, 0, 0, 32'h0});
    tbl.push_back('{16382, 4,     0, 1, 0,   0, 0, 1, 0, 32'h1});
    tbl.push_back('{0,     4,     0, 1, 100, 0, 1, 0, 0, 32'h0});
    tbl.push_back('{100,   0,     0, 0, 0,   0, 1, 0, 0, 32'h0});
    tbl.push_back('{10,    5,     1, 0, 0,   1, 1, 0, 0, 32'h0});
    tbl.push_back('{7,     16384, 1, 0, 0,   0, 1, 0, 0, 32'h0});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_chipselect", 64'(mem_chipselect), 64'd0);
    chk("rst_write", 64'(mem_write), 64'd0);
    chk("rst_address", 64'(mem_address), 64'd0);
    chk("rst_writedata", 64'(mem_writedata), 64'd0);
    chk("rst_status", 64'({busy, done, pass}), 64'd0);
    chk("rst_err", 64'({err_count, first_err_addr, first_err_data}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      run_test(tbl[i]);
      if (i == 1) begin
        chk("lfsr_word0", 64'(mem[0]), 64'h0000_0001);
        chk("lfsr_word1", 64'(mem[1]), 64'h8020_0003);
        chk("lfsr_word2", 64'(mem[2]), 64'hC030_0002);
      end
    end

    // Randomized runs checked against the word list and the fault position.
    for (int r = 0; r < 8; r++) begin
      n        = $urandom_range(1, 40);
      rv.base  = $urandom_range(0, 16383);
      rv.n     = n;
      rv.mode  = 1'($urandom);
      rv.fen   = 1'($urandom);
      off      = $urandom_range(0, n - 1);
      rv.faddr = (rv.base + off) % 16384;
      rv.start_mid = 1'($urandom);
      build(rv.base, rv.n, rv.mode);
      rv.exp_pass  = !rv.fen;
      rv.exp_err   = rv.fen ? 1 : 0;
      rv.exp_faddr = rv.fen ? rv.faddr : 0;
      rv.exp_fdata = rv.fen ? (exp_words[off] ^ 32'd1) : 32'd0;
      run_test(rv);
    end

    // Reset while DONE with a latched error clears all status.
    rv = '{0, 8, 0, 1, 3, 0, 0, 1, 3, 32'h2};
    run_test(rv);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_done_status", 64'({done, pass, err_count, first_err_addr}), 64'd0);

    // Reset in cycle N+2 (mid-READ) with a simultaneous start pulse.
    fault_en = 1'b0;
    base_addr = 14'd20; num_words = 15'd6; pattern_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("midread_pre", 64'({mem_chipselect, mem_write, busy}), 64'b101);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("midread_bus_idle", 64'({mem_chipselect, mem_write, mem_address}), 64'd0);
    chk("midread_status", 64'({busy, done, pass, err_count}), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("reset_start_ignored", 64'({mem_chipselect, busy, done}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
